// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, colour width and the
// control bundle that travels down the scan pipeline.
package vga_pkg;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;
    localparam int RD_LAT_D   = 1;
    localparam int RGB_W      = 8;

    // Sync flags are kept active-high so a cleared stage reads as idle
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } vga_ctl_t;

    function automatic logic in_win(input int c, input int lo, input int n);
        return (c >= lo) && (c < lo + n);
    endfunction

endpackage

// File: rtl/vga_fb_scan_if.sv
// vga_fb_scan_if: framebuffer port plus VGA pin bundle of the scan engine.
interface vga_fb_scan_if
    import vga_pkg::*;
#(
    parameter int HW = 10,
    parameter int VW = 9
);
    logic                 scale2x;
    logic [HW+VW-1:0]     fb_addr;
    logic [3*RGB_W-1:0]   fb_rdata;
    logic [HW-1:0]        h_addr;
    logic [VW-1:0]        v_addr;
    logic                 hsync;
    logic                 vsync;
    logic                 valid;
    logic [RGB_W-1:0]     vga_r;
    logic [RGB_W-1:0]     vga_g;
    logic [RGB_W-1:0]     vga_b;
    logic                 frame_start;

    modport master (
        input  scale2x, fb_rdata,
        output fb_addr, h_addr, v_addr, hsync, vsync, valid,
        output vga_r, vga_g, vga_b, frame_start
    );

    modport slave (
        output scale2x, fb_rdata,
        input  fb_addr, h_addr, v_addr, hsync, vsync, valid,
        input  vga_r, vga_g, vga_b, frame_start
    );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage register pipe with synchronous clear;
// DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    if (DEPTH == 0) begin : g_wire
        assign o_q = i_d;
    end else begin : g_pipe
        logic [WIDTH-1:0] r_pipe [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
            end else begin
                r_pipe[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign o_q = r_pipe[DEPTH-1];
    end
endmodule

// File: rtl/vga_fb_scan.sv
// vga_fb_scan: VGA timing generator and framebuffer scan-out with
// latency-matched sync/valid and optional 2x pixel doubling.
module vga_fb_scan
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter bit SYNC_POL = 1'b0,
    parameter int HW       = 10,
    parameter int VW       = 9,
    parameter int RD_LAT   = RD_LAT_D
) (
    input  logic          clk,
    input  logic          rst,
    vga_fb_scan_if.master bus
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW   = $clog2(H_TOT);
    localparam int VCW   = $clog2(V_TOT);

    typedef struct packed {
        logic [HW-1:0] h;
        logic [VW-1:0] v;
        vga_ctl_t      c;
    } bundle_t;

    logic [HCW-1:0]       r_hcnt;
    logic [VCW-1:0]       r_vcnt;
    logic                 r_scale;
    logic [HW+VW-1:0]     r_fb_addr;
    bundle_t              r_out;
    logic [3*RGB_W-1:0]   r_rgb;

    logic                 w_act;
    logic                 w_first;
    logic [HW-1:0]        w_hidx;
    logic [VW-1:0]        w_vidx;
    bundle_t              w_bun;
    bundle_t              w_dly;

    assign w_act   = in_win(int'(r_hcnt), 0, H_ACTIVE)
                  && in_win(int'(r_vcnt), 0, V_ACTIVE);
    assign w_first = (r_hcnt == '0) && (r_vcnt == '0);
    assign w_hidx  = HW'(r_scale ? (r_hcnt >> 1) : r_hcnt);
    assign w_vidx  = VW'(r_scale ? (r_vcnt >> 1) : r_vcnt);

    always_comb begin
        w_bun      = '0;
        w_bun.h    = HW'(r_hcnt);
        w_bun.v    = VW'(r_vcnt);
        w_bun.c.hs = in_win(int'(r_hcnt), H_ACTIVE + H_FP, H_SYNC);
        w_bun.c.vs = in_win(int'(r_vcnt), V_ACTIVE + V_FP, V_SYNC);
        w_bun.c.de = w_act;
        w_bun.c.fs = w_first;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt    <= '0;
            r_vcnt    <= '0;
            r_scale   <= 1'b0;
            r_fb_addr <= '0;
        end else begin
            if (int'(r_hcnt) == H_TOT - 1) begin
                r_hcnt <= '0;
                if (int'(r_vcnt) == V_TOT - 1) r_vcnt <= '0;
                else                           r_vcnt <= r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
            if (w_first) r_scale <= bus.scale2x;
            // blanking leaves the last active address on the bus
            if (w_act) r_fb_addr <= {w_hidx, w_vidx};
        end
    end

    // One stage for the address register plus RD_LAT memory cycles
    vga_delay_line #(
        .WIDTH ($bits(bundle_t)),
        .DEPTH (RD_LAT + 1)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .i_d (w_bun),
        .o_q (w_dly)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
            r_rgb <= '0;
        end else begin
            r_out <= w_dly;
            r_rgb <= w_dly.c.de ? bus.fb_rdata : '0;
        end
    end

    assign bus.fb_addr     = r_fb_addr;
    assign bus.h_addr      = r_out.h;
    assign bus.v_addr      = r_out.v;
    assign bus.hsync       = r_out.c.hs ? SYNC_POL : ~SYNC_POL;
    assign bus.vsync       = r_out.c.vs ? SYNC_POL : ~SYNC_POL;
    assign bus.valid       = r_out.c.de;
    assign bus.frame_start = r_out.c.fs;
    assign bus.vga_r       = r_rgb[3*RGB_W-1:2*RGB_W];
    assign bus.vga_g       = r_rgb[2*RGB_W-1:RGB_W];
    assign bus.vga_b       = r_rgb[RGB_W-1:0];
endmodule

// File: tb/tb_vga_fb_scan.sv
// tb_vga_fb_scan: small-timing scan engine with RD_LAT 1 and 3,
// scoreboarded against a reference timing model.
module tb_vga_fb_scan;

    localparam logic [34:0] RST_OUT = {1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 24'd0};
    localparam int NREC = 240;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scale2x = 1'b0;
    always #5 clk = ~clk;

    vga_fb_scan_if #(.HW(4), .VW(3)) ifa ();
    vga_fb_scan_if #(.HW(4), .VW(3)) ifb ();

    vga_fb_scan #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .HW(4), .VW(3), .RD_LAT(1)
    ) u_a (.clk(clk), .rst(rst), .bus(ifa));

    vga_fb_scan #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .HW(4), .VW(3), .RD_LAT(3)
    ) u_b (.clk(clk), .rst(rst), .bus(ifb));

    function automatic logic [23:0] fbd(input logic [6:0] a);
        return {8'hC3, 9'd0, a};
    endfunction

    function automatic logic [6:0] idx(input int h, input int v, input bit s);
        logic [3:0] hi;
        logic [2:0] vi;
        hi = 4'(s ? h / 2 : h);
        vi = 3'(s ? v / 2 : v);
        return {hi, vi};
    endfunction

    function automatic logic [34:0] exp_out(input int h, input int v, input bit s);
        logic act, hs, vs, fs;
        logic [23:0] rgb;
        act = (h < 8) && (v < 4);
        hs  = (h >= 10) && (h < 12);
        vs  = (v == 5);
        fs  = (h == 0) && (v == 0);
        rgb = act ? fbd(idx(h, v, s)) : 24'd0;
        return {act, ~hs, ~vs, fs, 4'(h), 3'(v), rgb};
    endfunction

    // framebuffer models: data is a tagged copy of the address
    logic [6:0] pa, pb1, pb2, pb3;
    always @(posedge clk) begin
        pa  <= ifa.fb_addr;
        pb1 <= ifb.fb_addr;
        pb2 <= pb1;
        pb3 <= pb2;
    end
    assign ifa.scale2x  = scale2x;
    assign ifb.scale2x  = scale2x;
    assign ifa.fb_rdata = fbd(pa);
    assign ifb.fb_rdata = fbd(pb3);

    logic [34:0] outa, outb;
    assign outa = {ifa.valid, ifa.hsync, ifa.vsync, ifa.frame_start,
                   ifa.h_addr, ifa.v_addr, ifa.vga_r, ifa.vga_g, ifa.vga_b};
    assign outb = {ifb.valid, ifb.hsync, ifb.vsync, ifb.frame_start,
                   ifb.h_addr, ifb.v_addr, ifb.vga_r, ifb.vga_g, ifb.vga_b};

    int nchk = 0;
    int npass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [34:0] qa[$];
    logic [34:0] qb[$];
    bit          armed[2];
    int          mh[2];
    int          mv[2];
    bit          ms[2];
    logic [6:0]  mfa[2];

    task automatic model_step(input int d, input logic [34:0] got,
                              input logic [6:0] gfa, input int pipe);
        logic [34:0] e;
        if (armed[d]) begin
            if (d == 0) e = qa.pop_front();
            else        e = qb.pop_front();
            chk(d == 0 ? "sb_out_a" : "sb_out_b", got, e);
            chk(d == 0 ? "fb_addr_a" : "fb_addr_b", gfa, mfa[d]);
        end
        if (rst) begin
            armed[d] = 1'b1;
            mh[d] = 0;
            mv[d] = 0;
            ms[d] = 1'b0;
            mfa[d] = '0;
            if (d == 0) begin
                qa.delete();
                repeat (pipe) qa.push_back(RST_OUT);
            end else begin
                qb.delete();
                repeat (pipe) qb.push_back(RST_OUT);
            end
        end else if (armed[d]) begin
            e = exp_out(mh[d], mv[d], ms[d]);
            if (d == 0) qa.push_back(e);
            else        qb.push_back(e);
            if (mh[d] < 8 && mv[d] < 4) mfa[d] = idx(mh[d], mv[d], ms[d]);
            if (mh[d] == 0 && mv[d] == 0) ms[d] = scale2x;
            if (mh[d] == 13) begin
                mh[d] = 0;
                mv[d] = (mv[d] == 6) ? 0 : mv[d] + 1;
            end else begin
                mh[d] = mh[d] + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0, outa, ifa.fb_addr, 3);
        model_step(1, outb, ifb.fb_addr, 5);
    end

    logic [34:0] rec_a [NREC];
    logic        rec_bv[NREC];
    logic [23:0] rec_brgb[NREC];

    initial begin
        int fa, fb, k, cnt, ka, kb, nva, nvb;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", ifa.valid, 1'b0);
        chk("rst_hsync", ifa.hsync, 1'b1);
        chk("rst_vsync", ifa.vsync, 1'b1);
        chk("rst_rgb", outa[23:0], 24'd0);
        chk("rst_out_b", outb, RST_OUT);
        rst = 1'b0;

        for (int i = 0; i < NREC; i++) begin
            rec_a[i]    = outa;
            rec_bv[i]   = ifb.valid;
            rec_brgb[i] = outb[23:0];
            if (i == 23) scale2x = 1'b1;
            @(posedge clk);
            #1;
        end

        fa = -1;
        fb = -1;
        for (int i = 0; i < 20; i++) begin
            if (fa < 0 && rec_a[i][34]) fa = i;
            if (fb < 0 && rec_bv[i]) fb = i;
        end
        chk("first_valid_a", fa, 3);
        chk("first_valid_b", fb, 5);
        if (fa < 0) fa = 0;
        if (fb < 0) fb = 0;
        chk("first_rgb_b", rec_brgb[fb], fbd(7'd0));
        chk("first_fs_a", rec_a[fa][31], 1'b1);
        chk("first_addr_a", rec_a[fa][30:24], 7'd0);

        cnt = 0;
        while (cnt < 20 && rec_a[fa+cnt][34]) cnt++;
        chk("valid_run", cnt, 8);
        k = 0;
        while (k < 14 && rec_a[fa+k][33]) k++;
        chk("hsync_start", k, 10);
        cnt = 0;
        for (int i = 0; i < 14; i++) if (!rec_a[fa+i][33]) cnt++;
        chk("hsync_width", cnt, 2);
        k = 9;
        while (k < 30 && !rec_a[fa+k][34]) k++;
        chk("line_period", k, 14);
        cnt = 0;
        for (int i = 0; i < 98; i++) if (!rec_a[fa+i][32]) cnt++;
        chk("vsync_width", cnt, 14);
        k = 1;
        while (k < 120 && !rec_a[fa+k][31]) k++;
        chk("frame_period", k, 98);

        chk("unscaled_col2", rec_a[fa+2][6:3], 4'd2);
        chk("unscaled_row1", rec_a[fa+14][2:0], 3'd1);
        for (int c = 0; c < 4; c++) begin
            chk("scaled_col", {rec_a[fa+98+c][30:27], rec_a[fa+98+c][6:3]},
                {4'(c), 4'(c / 2)});
            chk("scaled_row", {rec_a[fa+98+14*c][26:24], rec_a[fa+98+14*c][2:0]},
                {3'(c), 3'(c / 2)});
        end

        k = 0;
        while (k < 200 && !(mh[0] == 5 && mv[0] == 2)) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("find_5_2", k < 200, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_a", outa, RST_OUT);
        chk("mid_rst_b", outb, RST_OUT);
        ka = -1;
        kb = -1;
        nva = 0;
        nvb = 0;
        for (int i = 0; i < 20; i++) begin
            if (ka < 0 && ifa.frame_start) ka = i;
            if (kb < 0 && ifb.frame_start) kb = i;
            if (ka < 0 && ifa.valid) nva++;
            if (kb < 0 && ifb.valid) nvb++;
            @(posedge clk);
            #1;
        end
        chk("rst_fs_delay_a", ka, 3);
        chk("rst_fs_delay_b", kb, 5);
        chk("stale_valid_a", nva, 0);
        chk("stale_valid_b", nvb, 0);

        repeat (40) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
